// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - 64-bit fetch unit issuing one aligned request at a time and pushing up to two instruction words per response
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic [31:0] instructionA,
  output logic [31:0] instructionB,
  output logic [31:0] addressA,
  output logic [31:0] addressB,
  output logic        instructionA_valid,
  output logic        instructionB_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        resp_accept;

  // The request address is always the 8-byte line holding pc; pc only moves outside REQ
  // (or together with leaving REQ), so the address is stable while a request waits.
  assign mem_req_addr = {pc[31:3], 3'b000};
  assign pc_next      = {pc[31:3] + 29'd1, 3'b000};
  assign resp_accept  = (state_q == WAIT) && mem_resp_valid && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request-valid decode; a handshake coinciding with flush leaves a response in flight
  always_comb begin
    state_d       = state_q;
    mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && !stall) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (flush) begin
          state_d = mem_req_ready ? DISCARD : IDLE;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = mem_resp_valid ? IDLE : DISCARD;
        end else if (mem_resp_valid) begin
          state_d = stall ? IDLE : REQ;
        end
      end
      DISCARD: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC update and registered delivery of instruction words; strobes default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc                 <= {RESET_PC[31:2], 2'b00};
      instructionA       <= 32'h0;
      instructionB       <= 32'h0;
      addressA           <= 32'h0;
      addressB           <= 32'h0;
      instructionA_valid <= 1'b0;
      instructionB_valid <= 1'b0;
    end else begin
      instructionA_valid <= 1'b0;
      instructionB_valid <= 1'b0;
      if (flush) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (resp_accept) begin
        pc <= pc_next;
        instructionB_valid <= 1'b1;
        instructionB       <= mem_resp_data[63:32];
        if (!pc[2]) begin
          instructionA_valid <= 1'b1;
          instructionA       <= mem_resp_data[31:0];
          addressA           <= pc;
          addressB           <= {pc[31:3], 3'b100};
        end else begin
          addressB <= pc;
        end
      end
    end
  end

endmodule
